// File: rtl/uart_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decode
// Description : Frame decoder sitting behind uart_rx. Turns the received byte
//               stream into SDRAM test commands:
//                 WR_CMD + WR_BYTES payload -> FIFO writes, then wr_trig
//                 RD_CMD                    -> rd_trig
//                 any other command byte    -> cmd_err
//               Optional macro UART_CMD_TIMEOUT_EN adds an inter-byte idle
//               timeout in WR_DATA that aborts the frame with cmd_err.
// Ports       : sclk        - system clock
//               s_rst_n     - asynchronous active-low reset
//               uart_flag   - byte-valid strobe from uart_rx (po_flag)
//               uart_data   - received byte (rx_data)
//               wfifo_wr_en - write strobe to the SDRAM write FIFO
//               wfifo_data  - byte to the FIFO, held when strobe is low
//               wr_trig     - pulse after a complete write frame is pushed
//               rd_trig     - pulse on receipt of RD_CMD
//               cmd_err     - pulse on unknown command or frame timeout
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_decode #(
    parameter logic [7:0] WR_CMD      = 8'h55,
    parameter logic [7:0] RD_CMD      = 8'hAA,
    parameter int         WR_BYTES    = 4,
    parameter int         TIMEOUT_CYC = 5600
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       uart_flag,
    input  logic [7:0] uart_data,
    output logic       wfifo_wr_en,
    output logic [7:0] wfifo_data,
    output logic       wr_trig,
    output logic       rd_trig,
    output logic       cmd_err
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_WR_DATA = 1'b1
    } state_t;

    localparam logic [7:0] C_LAST_IDX = 8'(WR_BYTES - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       wr_pend_q;      // last payload pushed; trigger goes out next cycle
    logic       wfifo_wr_en_q;
    logic [7:0] wfifo_data_q;
    logic       wr_trig_q;
    logic       rd_trig_q;
    logic       cmd_err_q;

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] idle_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^(16'(TIMEOUT_CYC));
`endif

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            wr_pend_q     <= 1'b0;
            wfifo_wr_en_q <= 1'b0;
            wfifo_data_q  <= 8'h00;
            wr_trig_q     <= 1'b0;
            rd_trig_q     <= 1'b0;
            cmd_err_q     <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            idle_q        <= 16'd0;
`endif
        end else begin
            // Pulse outputs default low; wr_trig trails the final FIFO write
            wfifo_wr_en_q <= 1'b0;
            rd_trig_q     <= 1'b0;
            cmd_err_q     <= 1'b0;
            wr_trig_q     <= wr_pend_q;
            wr_pend_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (uart_flag) begin
                        if (uart_data == WR_CMD) begin
                            state_q <= S_WR_DATA;
                            cnt_q   <= 8'd0;
`ifdef UART_CMD_TIMEOUT_EN
                            idle_q  <= 16'd0;
`endif
                        end else if (uart_data == RD_CMD) begin
                            rd_trig_q <= 1'b1;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                end

                S_WR_DATA: begin
                    if (uart_flag) begin
                        // Every byte here is payload, command values included
                        wfifo_wr_en_q <= 1'b1;
                        wfifo_data_q  <= uart_data;
`ifdef UART_CMD_TIMEOUT_EN
                        idle_q        <= 16'd0;
`endif
                        if (cnt_q == C_LAST_IDX) begin
                            state_q   <= S_IDLE;
                            cnt_q     <= 8'd0;
                            wr_pend_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
`ifdef UART_CMD_TIMEOUT_EN
                    else if (idle_q == C_TO_LAST) begin
                        // Stalled frame: abort without a write trigger
                        cmd_err_q <= 1'b1;
                        state_q   <= S_IDLE;
                        cnt_q     <= 8'd0;
                        idle_q    <= 16'd0;
                    end else begin
                        idle_q <= idle_q + 16'd1;
                    end
`endif
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    assign wfifo_wr_en = wfifo_wr_en_q;
    assign wfifo_data  = wfifo_data_q;
    assign wr_trig     = wr_trig_q;
    assign rd_trig     = rd_trig_q;
    assign cmd_err     = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_decode
// Description : Self-checking bench for uart_cmd_decode. A behavioural model
//               in the byte driver pushes expected events (with the cycle
//               they must appear in) into per-output queues; a negedge
//               monitor pops and compares them as the DUT responds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decode;

    localparam int C_TO = 100;

    logic       sclk = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       uart_flag = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_data;
    logic       wr_trig;
    logic       rd_trig;
    logic       cmd_err;

    uart_cmd_decode #(
        .WR_CMD      (8'h55),
        .RD_CMD      (8'hAA),
        .WR_BYTES    (4),
        .TIMEOUT_CYC (C_TO)
    ) dut (
        .sclk        (sclk),
        .s_rst_n     (s_rst_n),
        .uart_flag   (uart_flag),
        .uart_data   (uart_data),
        .wfifo_wr_en (wfifo_wr_en),
        .wfifo_data  (wfifo_data),
        .wr_trig     (wr_trig),
        .rd_trig     (rd_trig),
        .cmd_err     (cmd_err)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } ev_t;

    ev_t q_fifo[$];
    int  q_wrt[$];
    int  q_rd[$];
    int  q_err[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit  m_in_frame = 1'b0;
    int  m_cnt = 0;
    int  m_last_flag = 0;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge sclk) begin
        ev_t e;
        int  c;
        if (s_rst_n) begin
            if (wfifo_wr_en) begin
                checks++;
                assert (q_fifo.size() != 0) else begin
                    errors++;
                    $error("FAIL fifo_unexpected: wr_en=1 data=%h at cyc %0d, expected none", wfifo_data, cyc);
                end
                if (q_fifo.size() != 0) begin
                    e = q_fifo.pop_front();
                    checks++;
                    assert (cyc === e.cyc) else begin
                        errors++;
                        $error("FAIL fifo_cycle: got cyc %0d, expected %0d", cyc, e.cyc);
                    end
                    checks++;
                    assert (wfifo_data === e.d) else begin
                        errors++;
                        $error("FAIL fifo_data: got %h, expected %h", wfifo_data, e.d);
                    end
                end
            end
            if (wr_trig) begin
                checks++;
                assert (q_wrt.size() != 0) else begin
                    errors++;
                    $error("FAIL wr_trig_unexpected: wr_trig=1 at cyc %0d, expected none", cyc);
                end
                if (q_wrt.size() != 0) begin
                    c = q_wrt.pop_front();
                    checks++;
                    assert (cyc === c) else begin
                        errors++;
                        $error("FAIL wr_trig_cycle: got cyc %0d, expected %0d", cyc, c);
                    end
                end
            end
            if (rd_trig) begin
                checks++;
                assert (q_rd.size() != 0) else begin
                    errors++;
                    $error("FAIL rd_trig_unexpected: rd_trig=1 at cyc %0d, expected none", cyc);
                end
                if (q_rd.size() != 0) begin
                    c = q_rd.pop_front();
                    checks++;
                    assert (cyc === c) else begin
                        errors++;
                        $error("FAIL rd_trig_cycle: got cyc %0d, expected %0d", cyc, c);
                    end
                end
            end
            if (cmd_err) begin
                checks++;
                assert (q_err.size() != 0) else begin
                    errors++;
                    $error("FAIL cmd_err_unexpected: cmd_err=1 at cyc %0d, expected none", cyc);
                end
                if (q_err.size() != 0) begin
                    c = q_err.pop_front();
                    checks++;
                    assert (cyc === c) else begin
                        errors++;
                        $error("FAIL cmd_err_cycle: got cyc %0d, expected %0d", cyc, c);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Drives one byte starting at the next negedge; consecutive calls give
    // back-to-back flags. The DUT samples at the following posedge, so its
    // response is visible at the negedge where cyc == c + 1.
    task automatic send(input logic [7:0] b);
        int c;
        @(negedge sclk);
        uart_flag = 1'b1;
        uart_data = b;
        c = cyc;
        m_last_flag = c;
        if (!m_in_frame) begin
            if (b == 8'h55) begin
                m_in_frame = 1'b1;
                m_cnt = 0;
            end else if (b == 8'hAA) begin
                q_rd.push_back(c + 1);
            end else begin
                q_err.push_back(c + 1);
            end
        end else begin
            q_fifo.push_back('{cyc: c + 1, d: b});
            m_cnt++;
            if (m_cnt == 4) begin
                m_in_frame = 1'b0;
                q_wrt.push_back(c + 2);
            end
        end
    endtask

    task automatic gap(input int n);
        @(negedge sclk);
        uart_flag = 1'b0;
        repeat (n - 1) @(negedge sclk);
    endtask

    task automatic check_quiet(input string tag);
        checks++;
        assert ({wfifo_wr_en, wfifo_data, wr_trig, rd_trig, cmd_err} === 12'h000) else begin
            errors++;
            $error("FAIL %s: outputs wr_en=%b data=%h wr_trig=%b rd_trig=%b cmd_err=%b, expected all 0",
                   tag, wfifo_wr_en, wfifo_data, wr_trig, rd_trig, cmd_err);
        end
    endtask

    task automatic check_drained(input string tag);
        checks++;
        assert ((q_fifo.size() + q_wrt.size() + q_rd.size() + q_err.size()) === 0) else begin
            errors++;
            $error("FAIL %s: pending fifo=%0d wr_trig=%0d rd_trig=%0d cmd_err=%0d, expected 0",
                   tag, q_fifo.size(), q_wrt.size(), q_rd.size(), q_err.size());
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        repeat (3) @(negedge sclk);
        check_quiet("reset_state");
        s_rst_n = 1'b1;
        repeat (2) @(negedge sclk);
        check_quiet("post_reset_idle");

        // Write frame with spaced bytes
        send(8'h55); gap(10);
        send(8'h11); gap(10);
        send(8'h22); gap(10);
        send(8'h33); gap(10);
        send(8'h44); gap(10);
        check_drained("write_frame");
        checks++;
        assert (wfifo_data === 8'h44) else begin
            errors++;
            $error("FAIL data_hold: got %h, expected 44", wfifo_data);
        end

        // Read command
        send(8'hAA); gap(5);
        check_drained("read_cmd");

        // Unknown byte, then payload that looks like commands (back-to-back)
        send(8'h3C); gap(5);
        send(8'h55); send(8'hAA); send(8'h55); send(8'hAA); send(8'h55);
        gap(5);
        check_drained("cmd_lookalike_payload");

        // Last payload immediately followed by a read: wr_trig and rd_trig coincide
        send(8'h55); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hAA);
        send(8'h99);
        gap(5);
        check_drained("back_to_back_overlap");

        // Stalled frame
        send(8'h55); gap(3);
        send(8'h11); gap(1);
`ifdef UART_CMD_TIMEOUT_EN
        q_err.push_back(m_last_flag + 1 + C_TO);
        m_in_frame = 1'b0;
        repeat (C_TO + 20) @(negedge sclk);
        check_drained("timeout_err");
        send(8'hAA); gap(5);
        check_drained("timeout_then_read");
`else
        repeat (10000) @(negedge sclk);
        check_drained("no_timeout_stall");
        send(8'h22); gap(4);
        send(8'h33); gap(4);
        send(8'h44); gap(5);
        check_drained("stall_resume_frame");
`endif

        // Mid-frame reset
        send(8'h55); gap(3);
        send(8'h11); gap(3);
        send(8'h22); gap(3);
        check_drained("pre_reset_writes");
        s_rst_n = 1'b0;
        m_in_frame = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sclk);
            check_quiet("in_reset");
        end
        s_rst_n = 1'b1;
        repeat (2) @(negedge sclk);
        send(8'hAA); gap(5);
        check_drained("reset_back_to_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
